// File: rtl/frame_scanout_reader.sv
// Frame RAM scan-out: VGA timing, linear read address, 2-stage palette pipeline.
// Everything except the palette write port advances only on pix_en.
module frame_scanout_reader #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int ADDR_W = 19,
  parameter int IDX_W  = 5
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              pix_en,
  output logic [ADDR_W-1:0] read_address,
  input  logic [IDX_W-1:0]  ram_data,
  input  logic              pal_we,
  input  logic [3:0]        pal_addr,
  input  logic [23:0]       pal_data,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_N,
  output logic              frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HC_W  = $clog2(H_TOT);
  localparam int VC_W  = $clog2(V_TOT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_VIS * V_VIS - 1);

  logic [HC_W-1:0] hc;
  logic [VC_W-1:0] vc;
  logic            vis0, hs0, vs0, end_line, end_frame;
  logic [3:0]      idx1;
  logic            vis1, hs1, vs1;
  logic [23:0]     palette [16];
  logic            ram_unused;

  assign ram_unused = ^ram_data[IDX_W-1:4];

  assign vis0      = (hc < HC_W'(H_VIS)) && (vc < VC_W'(V_VIS));
  assign hs0       = !((hc >= HC_W'(H_VIS + H_FP)) && (hc < HC_W'(H_VIS + H_FP + H_SYNC)));
  assign vs0       = !((vc >= VC_W'(V_VIS + V_FP)) && (vc < VC_W'(V_VIS + V_FP + V_SYNC)));
  assign end_line  = (hc == HC_W'(H_TOT - 1));
  assign end_frame = end_line && (vc == VC_W'(V_TOT - 1));

  // Palette writes ignore pix_en; a same-Clk lookup sees the old entry.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 16; i++) palette[i] <= {3{8'(i) * 8'h11}};
    end else if (pal_we) begin
      palette[pal_addr] <= pal_data;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hc           <= '0;
      vc           <= '0;
      read_address <= '0;
      frame_start  <= 1'b0;
      idx1         <= '0;
      vis1         <= 1'b0;
      hs1          <= 1'b1;
      vs1          <= 1'b1;
      VGA_R        <= '0;
      VGA_G        <= '0;
      VGA_B        <= '0;
      VGA_HS       <= 1'b1;
      VGA_VS       <= 1'b1;
      VGA_BLANK_N  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        if (end_line) begin
          hc <= '0;
          vc <= end_frame ? '0 : vc + VC_W'(1);
        end else begin
          hc <= hc + HC_W'(1);
        end
        frame_start <= end_frame;

        // Running address: advances on visible ticks only, so it already
        // points at the next line's first pixel during horizontal blanking.
        if (end_frame || (vis0 && read_address == LAST_ADDR))
          read_address <= '0;
        else if (vis0)
          read_address <= read_address + ADDR_W'(1);

        idx1 <= ram_data[3:0];
        vis1 <= vis0;
        hs1  <= hs0;
        vs1  <= vs0;

        {VGA_R, VGA_G, VGA_B} <= vis1 ? palette[idx1] : 24'h0;
        VGA_BLANK_N <= vis1;
        VGA_HS      <= hs1;
        VGA_VS      <= vs1;
      end
    end
  end

endmodule

// File: tb/tb_frame_scanout_reader.sv
// Directed bench for frame_scanout_reader; vertical timing shrunk to 10 lines
// (4 visible, sync on lines 6..7) so whole frames fit in a short run.
module tb_frame_scanout_reader;

  localparam int H_TOT = 800;
  localparam int V_VIS = 4;
  localparam int V_TOT = 10;
  localparam int FRAME = H_TOT * V_TOT;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        pix_en = 1'b0;
  logic [18:0] read_address;
  logic [4:0]  ram_data = 5'd0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_addr = 4'd0;
  logic [23:0] pal_data = 24'd0;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N, frame_start;

  int tests = 0, failed = 0;
  int t_hc = 0, t_vc = 0;
  int hs_low = 0, vs_low = 0, fs_cnt = 0, addr_err = 0, bad_blank = 0;
  int tick_no = 0, first_fs = 0;

  frame_scanout_reader #(.V_VIS(4), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_en(pix_en), .read_address(read_address),
    .ram_data(ram_data), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N), .frame_start(frame_start)
  );

  always #10 Clk = ~Clk;

  // Registered frame RAM model: index = addr[3:0], bit 4 set to prove it is ignored.
  always @(posedge Clk) ram_data <= {1'b1, read_address[3:0]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_addr(input int h, input int v);
    if (v < V_VIS) begin
      if (h < 640) return v * 640 + h;
      return (v == V_VIS - 1) ? 0 : (v + 1) * 640;
    end
    return 0;
  endfunction

  task automatic tick(input logic we = 1'b0, input logic [3:0] wa = 4'd0,
                      input logic [23:0] wd = 24'd0);
    @(negedge Clk);
    pix_en = 1'b1; pal_we = we; pal_addr = wa; pal_data = wd;
    @(negedge Clk);
    pix_en = 1'b0; pal_we = 1'b0;
    t_hc++;
    if (t_hc == H_TOT) begin
      t_hc = 0;
      t_vc = (t_vc == V_TOT - 1) ? 0 : t_vc + 1;
    end
    tick_no++;
    if (!VGA_HS) hs_low++;
    if (!VGA_VS) vs_low++;
    if (frame_start) begin
      fs_cnt++;
      if (first_fs == 0) first_fs = tick_no;
    end
    if (int'(read_address) != exp_addr(t_hc, t_vc)) addr_err++;
    if (!VGA_BLANK_N && {VGA_R, VGA_G, VGA_B} != 24'h0) bad_blank++;
  endtask

  task automatic run_to(input int h, input int v);
    int guard = 0;
    while (!(t_hc == h && t_vc == v)) begin
      tick();
      guard++;
      if (guard > 2 * FRAME) begin
        tests++; failed++;
        $error("FAIL run_to_timeout: observed no arrival expected (%0d,%0d)", h, v);
        break;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    chk("rst_addr", 32'(read_address), 0);
    chk("rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
    chk("rst_hs_vs", {VGA_HS, VGA_VS}, 2'b11);
    chk("rst_blank_fs", {VGA_BLANK_N, frame_start}, 2'b00);
    Reset_n = 1'b1;

    // Line 0: address trace, pipeline latency, HS window
    chk("addr_0_0", 32'(read_address), 0);
    run_to(5, 0);   chk("addr_5_0", 32'(read_address), 5);
    run_to(7, 0);   chk("rgb_pix5", {VGA_R, VGA_G, VGA_B}, 24'h555555);
                    chk("blank_pix5", VGA_BLANK_N, 1);
    run_to(639, 0); chk("addr_639_0", 32'(read_address), 639);
    run_to(640, 0); chk("addr_hold_640", 32'(read_address), 640);
    run_to(641, 0); chk("rgb_pix639", {VGA_R, VGA_G, VGA_B}, 24'hFFFFFF);
    run_to(642, 0); chk("rgb_blank", {VGA_R, VGA_G, VGA_B, 7'd0, VGA_BLANK_N}, 0);
    run_to(657, 0); chk("hs_655", VGA_HS, 1);
    run_to(658, 0); chk("hs_656", VGA_HS, 0);
    run_to(753, 0); chk("hs_751", VGA_HS, 0);
    run_to(754, 0); chk("hs_752", VGA_HS, 1);
    run_to(0, 1);   chk("addr_0_1", 32'(read_address), 640);
    hs_low = 0;

    // Palette write colliding with the index-3 lookup
    run_to(4, 1);
    tick(1'b1, 4'd3, 24'hFF0000);
    chk("pal_collision_old", {VGA_R, VGA_G, VGA_B}, 24'h333333);
    tick();
    chk("pal_other_entry", {VGA_R, VGA_G, VGA_B}, 24'h444444);
    run_to(21, 1);  chk("pal_new_red", {VGA_R, VGA_G, VGA_B}, 24'hFF0000);

    // pix_en stall mid-line
    run_to(30, 1);
    chk("stall_pre_addr", 32'(read_address), 670);
    chk("stall_pre_rgb", {VGA_R, VGA_G, VGA_B}, 24'hCCCCCC);
    repeat (10) @(negedge Clk);
    chk("stall_addr", 32'(read_address), 670);
    chk("stall_rgb", {VGA_R, VGA_G, VGA_B}, 24'hCCCCCC);
    tick();
    chk("resume_addr", 32'(read_address), 671);
    chk("resume_rgb", {VGA_R, VGA_G, VGA_B}, 24'hDDDDDD);

    run_to(0, 2);   chk("hs_low_per_line", hs_low, 96);
    run_to(639, 3); chk("addr_last", 32'(read_address), 2559);
    run_to(640, 3); chk("addr_wrap_hold", 32'(read_address), 0);
    run_to(0, 0);
    chk("addr_frame2", 32'(read_address), 0);
    chk("fs_one_per_frame", fs_cnt, 1);
    chk("vs_low_ticks", vs_low, 1600);

    // Frame 2: palette write without pix_en, then async reset mid-frame
    @(negedge Clk); pal_we = 1'b1; pal_addr = 4'd5; pal_data = 24'h00FF00;
    @(negedge Clk); pal_we = 1'b0;
    run_to(7, 0);   chk("pal_green", {VGA_R, VGA_G, VGA_B}, 24'h00FF00);
    run_to(300, 2);
    chk("pre_reset_rgb", {VGA_R, VGA_G, VGA_B}, 24'hAAAAAA);
    #3 Reset_n = 1'b0;
    #1;
    chk("async_addr", 32'(read_address), 0);
    chk("async_rgb", {VGA_R, VGA_G, VGA_B}, 0);
    chk("async_flags", {VGA_HS, VGA_VS, VGA_BLANK_N}, 3'b110);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    t_hc = 0; t_vc = 0; tick_no = 0; first_fs = 0; fs_cnt = 0;
    chk("restart_addr", 32'(read_address), 0);
    run_to(5, 0);   chk("restore_pal3", {VGA_R, VGA_G, VGA_B}, 24'h333333);
    run_to(7, 0);   chk("restore_pal5", {VGA_R, VGA_G, VGA_B}, 24'h555555);
    while (tick_no < FRAME) tick();
    chk("first_fs_tick", first_fs, FRAME);
    chk("fs_count_after_reset", fs_cnt, 1);

    chk("addr_trace_errors", addr_err, 0);
    chk("blank_rgb_errors", bad_blank, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
